// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button conditioning blocks.
package debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int CLK_HZ                  = 50_000_000;

  typedef enum logic {KEY_RELEASED, KEY_PRESSED} key_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One key: two-flop synchroniser, stability counter, debounced level,
// registered press/release pulses and a press-toggled level.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          IDLE_RAW = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic          s1_q, s2_q;
  logic [CW-1:0] count_q, count_d;
  key_state_t    level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          toggle_q, toggle_d;
  logic          raw_n;
  logic          differs;

  assign raw_n   = ACTIVE_LOW ? ~s2_q : s2_q;
  assign differs = raw_n != (level_q == KEY_PRESSED);

  // Any sample matching the accepted level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples moves the level.
  always_comb begin
    count_d   = count_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    if (!differs) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d   = '0;
      level_d   = raw_n ? KEY_PRESSED : KEY_RELEASED;
      press_d   = raw_n;
      release_d = ~raw_n;
      toggle_d  = toggle_q ^ raw_n;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= IDLE_RAW;
      s2_q      <= IDLE_RAW;
      count_q   <= '0;
      level_q   <= KEY_RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      s1_q      <= key_raw;
      s2_q      <= s1_q;
      count_q   <= count_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign key_level   = (level_q == KEY_PRESSED);
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_toggle  = toggle_q;

endmodule

// File: rtl/key_debounce_pulser.sv
// Bank of independent debounced key channels; all outputs are registered.
module key_debounce_pulser
  import debounce_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_toggle
);

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_channel (
        .clock      (clock),
        .reset      (reset),
        .key_raw    (key_raw[gi]),
        .key_level  (key_level[gi]),
        .key_press  (key_press[gi]),
        .key_release(key_release[gi]),
        .key_toggle (key_toggle[gi])
      );
    end
  endgenerate

endmodule
